// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_pkg
// Brief    : Shared Wishbone cycle-type codes and frame-reader state encoding.
// Revision : 1.0
// ============================================================================
package video_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // S_ prefix keeps the burst state distinct from the BURST length parameter.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_PAUSE = 2'd2
    } rd_state_t;

    function automatic logic [2:0] cti_for(input logic last);
        return last ? CTI_EOB : CTI_INCR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pixel_fifo
// Brief    : Synchronous show-ahead FIFO with flush; head entry is always on rdata.
// Revision : 1.0
// ============================================================================
module pixel_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB tells full from empty when the index bits match.
    assign empty  = (r_wptr == r_rptr);
    assign w_full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push = wr && !w_full && !flush;
    assign w_pop  = rd && !empty && !flush;
    assign level  = r_wptr - r_rptr;
    assign rdata  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wshb_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : wshb_frame_reader
// Brief    : Wishbone burst read master streaming a 32bpp framebuffer as 24-bit pixels.
// Revision : 1.0
// ============================================================================
module wshb_frame_reader
    import video_pkg::*;
#(
    parameter int          HDISP      = 800,
    parameter int          VDISP      = 480,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          BURST      = 16,
    parameter int          FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_restart,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic [31:0] wshb_adr,
    output logic        wshb_we,
    output logic [3:0]  wshb_sel,
    output logic [31:0] wshb_dat_ms,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    input  logic [31:0] wshb_dat_sm,
    input  logic        wshb_ack,
    output logic [23:0] pix_data,
    output logic        pix_sof,
    output logic        pix_valid,
    input  logic        pix_ready
);

    localparam int NPIX = HDISP * VDISP;
    localparam int IDXW = $clog2(NPIX);
    localparam int BW   = $clog2(BURST);
    localparam int LW   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [IDXW-1:0] c_last_idx  = IDXW'(NPIX - 1);
    localparam logic [BW-1:0]   c_last_beat = BW'(BURST - 1);
    localparam logic [LW-1:0]   c_depth     = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]   c_burst     = LW'(BURST);

    rd_state_t         r_state;
    logic              r_cyc;
    logic [31:0]       r_adr;
    logic [2:0]        r_cti;
    logic [IDXW-1:0]   r_idx;
    logic [BW-1:0]     r_beat;

    logic [LW-1:0]     w_level;
    logic [LW-1:0]     w_free;
    logic              w_empty;
    logic [24:0]       w_rdata;
    logic [24:0]       w_wdata;
    logic              w_ack;
    logic              w_fifo_wr;
    logic              w_pop;
    logic              w_last;
    logic              w_next_last;
    logic              w_start;
    logic              w_unused;

    assign w_ack       = (r_state == S_BURST) && wshb_ack;
    assign w_fifo_wr   = w_ack && !frame_restart;
    assign w_wdata     = {(r_idx == '0), wshb_dat_sm[23:0]};
    assign w_pop       = pix_ready && !w_empty;
    assign w_last      = (r_beat == c_last_beat) || (r_idx == c_last_idx);
    assign w_next_last = ((r_beat + BW'(1)) == c_last_beat) || ((r_idx + IDXW'(1)) == c_last_idx);
    // Level is exact outside BURST, so no separate reservation counter is needed.
    assign w_free      = c_depth - w_level;
    assign w_start     = enable && (w_free >= c_burst);
    assign w_unused    = ^wshb_dat_sm[31:24];

    pixel_fifo #(
        .WIDTH (25),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (frame_restart),
        .wr    (w_fifo_wr),
        .wdata (w_wdata),
        .rd    (w_pop),
        .rdata (w_rdata),
        .empty (w_empty),
        .level (w_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cyc   <= 1'b0;
            r_adr   <= BASE_ADDR;
            r_cti   <= CTI_CLASSIC;
            r_idx   <= '0;
            r_beat  <= '0;
        end else if (frame_restart) begin
            r_state <= S_PAUSE;
            r_cyc   <= 1'b0;
            r_adr   <= BASE_ADDR;
            r_cti   <= CTI_CLASSIC;
            r_idx   <= '0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                // Pause shares the start decision with idle so the bus is
                // released for exactly one cycle when the FIFO has room.
                S_IDLE, S_PAUSE: begin
                    if (w_start) begin
                        r_state <= S_BURST;
                        r_cyc   <= 1'b1;
                        r_beat  <= '0;
                        r_cti   <= cti_for(r_idx == c_last_idx);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BURST: begin
                    if (wshb_ack) begin
                        if (r_idx == c_last_idx) begin
                            r_idx <= '0;
                            r_adr <= BASE_ADDR;
                        end else begin
                            r_idx <= r_idx + IDXW'(1);
                            r_adr <= r_adr + 32'd4;
                        end
                        if (w_last) begin
                            r_state <= S_PAUSE;
                            r_cyc   <= 1'b0;
                            r_cti   <= CTI_CLASSIC;
                            r_beat  <= '0;
                        end else begin
                            r_beat  <= r_beat + BW'(1);
                            r_cti   <= cti_for(w_next_last);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase
        end
    end

    assign wshb_cyc    = r_cyc;
    assign wshb_stb    = r_cyc;
    assign wshb_adr    = r_adr;
    assign wshb_cti    = r_cti;
    assign wshb_we     = 1'b0;
    assign wshb_sel    = 4'hF;
    assign wshb_dat_ms = 32'h0;
    assign wshb_bte    = BTE_LINEAR;

    assign pix_valid   = !w_empty;
    assign pix_data    = w_rdata[23:0];
    assign pix_sof     = w_rdata[24];

endmodule
`default_nettype wire

// File: tb/tb_wshb_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_wshb_frame_reader
// Brief    : Randomized bench with SDRAM slave and pixel-stream reference model.
// Revision : 1.0
// ============================================================================
module tb_wshb_frame_reader;

    localparam int          HDISP = 10;
    localparam int          VDISP = 4;
    localparam int          NPIX  = HDISP * VDISP;
    localparam int          BURST = 16;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        frame_restart = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] dat_sm = 32'h0;
    logic        ready = 1'b0;

    logic        cyc, stb, we;
    logic [31:0] adr, dat_ms;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [23:0] pix_data;
    logic        pix_sof, pix_valid;

    always #5 clk = ~clk;

    wshb_frame_reader #(
        .HDISP      (HDISP),
        .VDISP      (VDISP),
        .BASE_ADDR  (BASE),
        .BURST      (BURST),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .frame_restart (frame_restart),
        .wshb_cyc      (cyc),
        .wshb_stb      (stb),
        .wshb_adr      (adr),
        .wshb_we       (we),
        .wshb_sel      (sel),
        .wshb_dat_ms   (dat_ms),
        .wshb_cti      (cti),
        .wshb_bte      (bte),
        .wshb_dat_sm   (dat_sm),
        .wshb_ack      (ack),
        .pix_data      (pix_data),
        .pix_sof       (pix_sof),
        .pix_valid     (pix_valid),
        .pix_ready     (ready)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
    endfunction

    function automatic logic [24:0] pix_of(input int p);
        logic [31:0] w;
        w = mem_word(BASE + 32'(p) * 32'd4);
        return {(p == 0), w[23:0]};
    endfunction

    // Reference model: expected FIFO contents, next frame pixel, beat in burst.
    logic [24:0] q[$];
    int          exp_p = 0;
    int          m_beat = 0;
    int          beats_total = 0;
    int          low_run = 0;
    logic        exp_cyc = 1'b0;
    logic        prev_cyc = 1'b0;
    logic [31:0] eob_adr[$];
    logic [31:0] start_adr[$];
    int          gaps[$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_cyc", {31'b0, cyc}, 32'd0);
                chk("rst_valid", {31'b0, pix_valid}, 32'd0);
                chk("rst_adr", adr, BASE);
                chk("rst_cti", {29'b0, cti}, 32'd0);
                q.delete();
                exp_p = 0; m_beat = 0; exp_cyc = 1'b0; prev_cyc = 1'b0; low_run = 0;
            end else begin
                automatic int   sz = q.size();
                automatic logic last = (m_beat == BURST - 1) || (exp_p == NPIX - 1);
                chk("cyc", {31'b0, cyc}, {31'b0, exp_cyc});
                chk("stb", {31'b0, stb}, {31'b0, exp_cyc});
                chk("we", {31'b0, we}, 32'd0);
                chk("sel_bte", {26'b0, sel, bte}, {26'b0, 4'hF, 2'b00});
                chk("dat_ms", dat_ms, 32'd0);
                chk("pix_valid", {31'b0, pix_valid}, {31'b0, (sz != 0)});
                if (sz != 0) chk("pixel", {7'b0, pix_sof, pix_data}, {7'b0, q[0]});
                if (cyc) begin
                    chk("adr", adr, BASE + 32'(exp_p) * 32'd4);
                    chk("cti", {29'b0, cti}, {29'b0, (last ? 3'b111 : 3'b010)});
                end
                if (cyc && !prev_cyc) begin
                    start_adr.push_back(adr);
                    gaps.push_back(low_run);
                    low_run = 0;
                end
                if (!cyc) low_run++;
                prev_cyc = cyc;
                if (frame_restart) begin
                    q.delete();
                    exp_p = 0; m_beat = 0; exp_cyc = 1'b0;
                end else begin
                    if (sz != 0 && ready) void'(q.pop_front());
                    if (cyc && ack) begin
                        q.push_back(pix_of(exp_p));
                        beats_total++;
                        if (last) eob_adr.push_back(adr);
                        exp_p = (exp_p + 1) % NPIX;
                        m_beat++;
                        if (last) begin
                            exp_cyc = 1'b0;
                            m_beat  = 0;
                        end else begin
                            exp_cyc = 1'b1;
                        end
                    end else if (cyc) begin
                        exp_cyc = 1'b1;
                    end else begin
                        exp_cyc = enable && ((DEPTH - sz) >= BURST);
                    end
                end
            end
        end
    end

    // SDRAM slave: classic cycles, configurable wait states, optional restart at beat 5.
    int   wcnt = 0;
    int   wait_mode = 0;
    logic restart_arm = 1'b0;
    logic restart_fired = 1'b0;

    function automatic int pick_wait(input int mode);
        if (mode == 1) return 3;
        if (mode == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            frame_restart = 1'b0;
            if (cyc && stb && !rst) begin
                if (wcnt == 0) begin
                    ack    = 1'b1;
                    dat_sm = mem_word(adr);
                    wcnt   = pick_wait(wait_mode);
                    if (restart_arm && m_beat == 5) begin
                        frame_restart = 1'b1;
                        restart_arm   = 1'b0;
                        restart_fired = 1'b1;
                    end
                end else begin
                    ack    = 1'b0;
                    dat_sm = $urandom;
                    wcnt   = wcnt - 1;
                end
            end else begin
                ack    = 1'b0;
                dat_sm = $urandom;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cyc", {31'b0, cyc}, 32'd0);
        chk("post_rst_adr", adr, BASE);

        // FIFO fills with ready low: bursts of 16, 16, 8 (frame end), 16.
        @(posedge clk); #1;
        enable = 1'b1;
        repeat (120) @(posedge clk);
        @(negedge clk);
        chk("fill_beats", beats_total, 32'd56);
        chk("fill_cyc_idle", {31'b0, cyc}, 32'd0);
        chk("fill_bursts", start_adr.size(), 32'd4);
        if (start_adr.size() >= 4 && eob_adr.size() >= 3 && gaps.size() >= 4) begin
            chk("burst0_start", start_adr[0], 32'h100);
            chk("burst0_eob", eob_adr[0], 32'h13C);
            chk("burst2_eob_frame_end", eob_adr[2], 32'h19C);
            chk("burst3_wrap", start_adr[3], 32'h100);
            chk("gap1", gaps[1], 32'd1);
            chk("gap2", gaps[2], 32'd1);
            chk("gap3", gaps[3], 32'd1);
        end
        chk("head_sof", {31'b0, pix_sof}, 32'd1);

        // Raising ready: 8 pops free 16 slots, then a burst starts.
        @(posedge clk); #1;
        ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cyc && n < 40);
        chk("resume_latency", n, 32'd10);
        repeat (200) @(posedge clk);

        // Three wait states per beat.
        #1;
        wait_mode = 1;
        repeat (300) @(posedge clk);

        // Random waits, back-pressure and enable.
        wait_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            ready  = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 7) != 0);
        end

        // Drain, then restart mid-burst at beat 5 with an ack in the same cycle.
        @(posedge clk); #1;
        wait_mode = 0; enable = 1'b0; ready = 1'b1;
        repeat (150) @(posedge clk);
        #1;
        ready = 1'b0; enable = 1'b1; restart_arm = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!restart_fired && n < 500);
        chk("restart_fired", {31'b0, restart_fired}, 32'd1);
        @(negedge clk);
        chk("restart_pre_valid", {31'b0, pix_valid}, 32'd1);
        chk("restart_pre_ack", {30'b0, frame_restart, ack}, 32'd3);
        @(negedge clk);
        chk("restart_cyc", {31'b0, cyc}, 32'd0);
        chk("restart_flush", {31'b0, pix_valid}, 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cyc && n < 40);
        chk("restart_adr", adr, BASE);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pix_valid && n < 40);
        chk("restart_sof", {31'b0, pix_sof}, 32'd1);

        // Asynchronous reset in the middle of a burst.
        @(posedge clk); #1;
        ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cyc && n < 100);
        chk("pre_async_cyc", {31'b0, cyc}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_cyc", {31'b0, cyc}, 32'd0);
        chk("async_stb", {31'b0, stb}, 32'd0);
        chk("async_valid", {31'b0, pix_valid}, 32'd0);
        chk("async_adr", adr, BASE);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_mode = 2;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            ready = ($urandom_range(0, 1) != 0);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
